// File: rtl/jtpopeye_objdma_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtpopeye_objdma_if
//  Description : Bus bundle for the Popeye object-table DMA. Carries timing
//                inputs, the Z80 bus handshake, the CPU-side read port and
//                the object line RAM write port.
//                master : the DMA engine side.
//                slave  : the system side (timing, CPU bus, object RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
interface jtpopeye_objdma_if;

    // Timing and control
    logic       pxl_cen;
    logic       VB;
    logic       DM10;

    // Z80 bus handshake
    logic       busak_n;
    logic       busrq_n;

    // CPU-side read port
    logic [9:0] src_addr;
    logic       src_rd;
    logic [7:0] src_din;

    // Object line RAM write port
    logic [7:0] obj_addr;
    logic [7:0] obj_dout;
    logic       obj_we;

    // Status
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        input  pxl_cen,
        input  VB,
        input  DM10,
        input  busak_n,
        input  src_din,
        output busrq_n,
        output src_addr,
        output src_rd,
        output obj_addr,
        output obj_dout,
        output obj_we,
        output busy,
        output done,
        output overrun
    );

    modport slave (
        output pxl_cen,
        output VB,
        output DM10,
        output busak_n,
        output src_din,
        input  busrq_n,
        input  src_addr,
        input  src_rd,
        input  obj_addr,
        input  obj_dout,
        input  obj_we,
        input  busy,
        input  done,
        input  overrun
    );

endinterface
`default_nettype wire

// File: rtl/jtpopeye_objdma.sv
`default_nettype none
// ============================================================================
//  Module      : jtpopeye_objdma
//  Description : Object-table DMA scheduler. Once armed by DM10, copies LEN
//                bytes from the CPU-side object table into the object line
//                RAM at the next rising edge of vertical blank. Requests the
//                Z80 bus, moves one byte every two pixel-clock enables and
//                hands the bus back. A copy that VB cuts short is flagged in
//                the sticky overrun bit.
//                Optional: define JTPOPEYE_DMA_WATCHDOG_EN to bound the time
//                spent waiting for bus grant / bus release to 255 pxl_cen.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtpopeye_objdma #(
    parameter int         LEN      = 160,
    parameter logic [9:0] SRC_BASE = 10'h000,
    parameter logic [7:0] DST_BASE = 8'h00
) (
    input wire                clk,
    input wire                rst,
    jtpopeye_objdma_if.master bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_req     = 3'd1;
    localparam logic [2:0] c_st_read    = 3'd2;
    localparam logic [2:0] c_st_write   = 3'd3;
    localparam logic [2:0] c_st_release = 3'd4;

    // Index of the final byte of a transfer
    localparam logic [7:0] c_last_idx   = 8'(LEN - 1);

`ifdef JTPOPEYE_DMA_WATCHDOG_EN
    // Counter value at which the 255th pxl_cen in REQ/RELEASE forces an exit
    localparam logic [7:0] c_wd_last    = 8'd254;
`endif

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0] state_q,    state_d;
    logic       vb_q,       vb_d;
    logic       armed_q,    armed_d;
    logic [7:0] index_q,    index_d;
    logic       busrq_n_q,  busrq_n_d;
    logic [9:0] src_addr_q, src_addr_d;
    logic       src_rd_q,   src_rd_d;
    logic [7:0] obj_addr_q, obj_addr_d;
    logic [7:0] obj_dout_q, obj_dout_d;
    logic       obj_we_q,   obj_we_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       overrun_q,  overrun_d;
`ifdef JTPOPEYE_DMA_WATCHDOG_EN
    logic [7:0] wd_q,       wd_d;
`endif

    // Rising edge of VB, relative to the value seen on the previous pxl_cen
    logic vb_rise;
    assign vb_rise = bus.VB & ~vb_q;

    // Next-state and output logic; everything advances only on pxl_cen,
    // while the write strobe and completion pulse fall back to 0 every clk.
    always_comb begin
        state_d    = state_q;
        vb_d       = vb_q;
        armed_d    = armed_q;
        index_d    = index_q;
        busrq_n_d  = busrq_n_q;
        src_addr_d = src_addr_q;
        src_rd_d   = src_rd_q;
        obj_addr_d = obj_addr_q;
        obj_dout_d = obj_dout_q;
        obj_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
`ifdef JTPOPEYE_DMA_WATCHDOG_EN
        wd_d       = wd_q;
`endif

        if (bus.pxl_cen) begin
            vb_d = bus.VB;

            case (state_q)
                c_st_idle: begin
                    // An arm on the same enable as the VB edge still counts
                    if (vb_rise && (armed_q || bus.DM10)) begin
                        state_d   = c_st_req;
                        armed_d   = 1'b0;
                        busrq_n_d = 1'b0;
                        busy_d    = 1'b1;
                        if (bus.DM10) begin
                            overrun_d = 1'b0;
                        end
                    end else if (bus.DM10) begin
                        armed_d   = 1'b1;
                        overrun_d = 1'b0;
                    end
                end

                c_st_req: begin
                    if (!bus.busak_n) begin
                        state_d = c_st_read;
                        index_d = 8'd0;
                    end else if (!bus.VB) begin
                        // Blanking ended before the CPU gave up the bus
                        state_d   = c_st_release;
                        busrq_n_d = 1'b1;
                        overrun_d = 1'b1;
                    end
                end

                c_st_read: begin
                    src_addr_d = SRC_BASE + {2'b00, index_q};
                    src_rd_d   = 1'b1;
                    state_d    = c_st_write;
                    // VB dropping here still lets the byte in flight land;
                    // overrun then stops the copy after that write.
                    if (!bus.VB) begin
                        overrun_d = 1'b1;
                    end
                end

                c_st_write: begin
                    obj_dout_d = bus.src_din;
                    obj_addr_d = DST_BASE + index_q;
                    obj_we_d   = 1'b1;
                    src_rd_d   = 1'b0;
                    if (overrun_q || !bus.VB) begin
                        overrun_d = 1'b1;
                        state_d   = c_st_release;
                        busrq_n_d = 1'b1;
                    end else if (index_q == c_last_idx) begin
                        state_d   = c_st_release;
                        busrq_n_d = 1'b1;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = c_st_read;
                    end
                end

                c_st_release: begin
                    busrq_n_d = 1'b1;
                    if (bus.busak_n) begin
                        state_d = c_st_idle;
                        busy_d  = 1'b0;
                        done_d  = ~overrun_q;
                    end
                end

                default: begin
                    state_d   = c_st_idle;
                    busrq_n_d = 1'b1;
                    src_rd_d  = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase

`ifdef JTPOPEYE_DMA_WATCHDOG_EN
            // Bound the bus handshake waits; the count restarts whenever
            // the state moves on.
            if (state_d != state_q) begin
                wd_d = 8'd0;
            end else if (state_q == c_st_req || state_q == c_st_release) begin
                if (wd_q == c_wd_last) begin
                    wd_d      = 8'd0;
                    overrun_d = 1'b1;
                    busrq_n_d = 1'b1;
                    if (state_q == c_st_req) begin
                        state_d = c_st_release;
                    end else begin
                        state_d = c_st_idle;
                        busy_d  = 1'b0;
                        done_d  = 1'b0;
                    end
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
`endif
        end
    end

    // State and output registers; reset drops the bus request immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_st_idle;
            vb_q       <= 1'b0;
            armed_q    <= 1'b0;
            index_q    <= 8'd0;
            busrq_n_q  <= 1'b1;
            src_addr_q <= SRC_BASE;
            src_rd_q   <= 1'b0;
            obj_addr_q <= DST_BASE;
            obj_dout_q <= 8'd0;
            obj_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vb_q       <= vb_d;
            armed_q    <= armed_d;
            index_q    <= index_d;
            busrq_n_q  <= busrq_n_d;
            src_addr_q <= src_addr_d;
            src_rd_q   <= src_rd_d;
            obj_addr_q <= obj_addr_d;
            obj_dout_q <= obj_dout_d;
            obj_we_q   <= obj_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef JTPOPEYE_DMA_WATCHDOG_EN
    // Handshake watchdog counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busrq_n  = busrq_n_q;
    assign bus.src_addr = src_addr_q;
    assign bus.src_rd   = src_rd_q;
    assign bus.obj_addr = obj_addr_q;
    assign bus.obj_dout = obj_dout_q;
    assign bus.obj_we   = obj_we_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_jtpopeye_objdma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtpopeye_objdma
//  Description : Self-checking bench for jtpopeye_objdma. A scoreboard queue
//                holds the object RAM writes each scenario expects; a
//                monitor pops and compares every obj_we pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtpopeye_objdma;

    localparam int         C_LEN = 160;
    localparam logic [9:0] C_SRC = 10'h3C0;   // makes the 10-bit source wrap
    localparam logic [7:0] C_DST = 8'h00;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk;
    logic rst;
    jtpopeye_objdma_if bus ();

    wr_t exp_q[$];
    int  n_checks;
    int  n_pass;
    int  we_cnt;
    int  done_cnt;
    int  cen_cnt;

    jtpopeye_objdma #(
        .LEN      (C_LEN),
        .SRC_BASE (C_SRC),
        .DST_BASE (C_DST)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // CPU-side object table contents
    function automatic logic [7:0] src_model(input logic [9:0] a);
        logic [7:0] t;
        t = a[7:0] * 8'd5 + 8'd3;
        return t ^ {a[9:8], 6'h15};
    endfunction

    assign bus.src_din = src_model(bus.src_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One pixel enable every three system clocks
    initial begin
        bus.pxl_cen = 1'b0;
        cen_cnt     = 0;
        forever begin
            @(negedge clk);
            bus.pxl_cen = (cen_cnt == 2);
            cen_cnt     = (cen_cnt + 1) % 3;
        end
    end

    // Scoreboard monitor for object RAM writes and done pulses
    always @(negedge clk) begin
        if (bus.obj_we === 1'b1) begin
            wr_t e;
            we_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL obj_write: unexpected write addr=%h data=%h, required no write",
                         bus.obj_addr, bus.obj_dout);
            end else begin
                e = exp_q.pop_front();
                if ({bus.obj_addr, bus.obj_dout} !== {e.a, e.d})
                    $display("FAIL obj_write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.obj_addr, bus.obj_dout, e.a, e.d);
                else
                    n_pass++;
            end
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    // Advance to just after the next clk edge that carries a pixel enable
    task automatic cen_tick();
        do @(posedge clk); while (bus.pxl_cen !== 1'b1);
        #1;
    endtask

    task automatic arm();
        bus.DM10 = 1'b1;
        cen_tick();
        bus.DM10 = 1'b0;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({8'(C_DST + 8'(i)), src_model(10'(C_SRC + 10'(i)))});
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.busrq_n, bus.src_rd, bus.obj_we, bus.busy, bus.done, bus.overrun} !== 6'b100000)
            $display("FAIL reset_ctrl: got busrq_n,src_rd,obj_we,busy,done,overrun=%b, required 100000",
                     {bus.busrq_n, bus.src_rd, bus.obj_we, bus.busy, bus.done, bus.overrun});
        else n_pass++;
        n_checks++;
        if (bus.src_addr !== C_SRC)
            $display("FAIL reset_src_addr: got %h, required %h", bus.src_addr, C_SRC);
        else n_pass++;
        n_checks++;
        if (bus.obj_addr !== C_DST)
            $display("FAIL reset_obj_addr: got %h, required %h", bus.obj_addr, C_DST);
        else n_pass++;
    endtask

    task automatic test_normal_copy(input string name);
        int base_we, base_done, t;
        base_we   = we_cnt;
        base_done = done_cnt;
        arm();
        n_checks++;
        if (bus.busrq_n !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL %s_armed_idle: got busrq_n=%b busy=%b, required 1 0", name, bus.busrq_n, bus.busy);
        else n_pass++;
        push_exp(C_LEN);
        bus.VB = 1'b1;
        cen_tick();
        n_checks++;
        if (bus.busrq_n !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL %s_request: got busrq_n=%b busy=%b, required 0 1", name, bus.busrq_n, bus.busy);
        else n_pass++;
        repeat (3) cen_tick();
        bus.busak_n = 1'b0;
        t = 0;
        while (bus.busrq_n !== 1'b1 && t < 2000) begin
            cen_tick();
            t++;
            // An arm request while busy must be ignored
            if (t == 20) bus.DM10 = 1'b1;
            if (t == 22) bus.DM10 = 1'b0;
        end
        n_checks++;
        if (t >= 2000) $display("FAIL %s_release_timeout: got %0d pxl_cen, required < 2000", name, t);
        else n_pass++;
        n_checks++;
        if (done_cnt != base_done)
            $display("FAIL %s_done_early: got %0d done pulses before release, required 0", name, done_cnt - base_done);
        else n_pass++;
        bus.busak_n = 1'b1;
        repeat (4) cen_tick();
        n_checks++;
        if (we_cnt - base_we != C_LEN)
            $display("FAIL %s_write_count: got %0d, required %0d", name, we_cnt - base_we, C_LEN);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_missing_writes: got %0d left, required 0", name, exp_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt - base_done != 1)
            $display("FAIL %s_done: got %0d pulses, required 1", name, done_cnt - base_done);
        else n_pass++;
        n_checks++;
        if (bus.overrun !== 1'b0 || bus.busy !== 1'b0 || bus.busrq_n !== 1'b1)
            $display("FAIL %s_end_status: got overrun=%b busy=%b busrq_n=%b, required 0 0 1",
                     name, bus.overrun, bus.busy, bus.busrq_n);
        else n_pass++;
        bus.VB = 1'b0;
        repeat (4) cen_tick();
        exp_q.delete();
    endtask

    task automatic test_not_armed();
        int base_we, low_seen;
        base_we  = we_cnt;
        low_seen = 0;
        bus.VB = 1'b1;
        repeat (40) begin
            cen_tick();
            if (bus.busrq_n !== 1'b1) low_seen++;
        end
        bus.VB = 1'b0;
        repeat (5) cen_tick();
        n_checks++;
        if (low_seen != 0)
            $display("FAIL not_armed_busrq: got %0d pxl_cen with busrq_n low, required 0", low_seen);
        else n_pass++;
        n_checks++;
        if (we_cnt != base_we || bus.busy !== 1'b0)
            $display("FAIL not_armed_activity: got %0d writes busy=%b, required 0 0", we_cnt - base_we, bus.busy);
        else n_pass++;
    endtask

    task automatic test_grant_late();
        int base_we, base_done, t;
        base_we   = we_cnt;
        base_done = done_cnt;
        arm();
        bus.VB = 1'b1;
        cen_tick();
        n_checks++;
        if (bus.busrq_n !== 1'b0)
            $display("FAIL late_request: got busrq_n=%b, required 0", bus.busrq_n);
        else n_pass++;
        repeat (39) cen_tick();
        bus.VB = 1'b0;
        t = 0;
        while (bus.busrq_n !== 1'b1 && t < 10) begin
            cen_tick();
            t++;
        end
        n_checks++;
        if (t >= 10) $display("FAIL late_release_timeout: got %0d pxl_cen, required < 10", t);
        else n_pass++;
        repeat (3) cen_tick();
        n_checks++;
        if (bus.overrun !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL late_status: got overrun=%b busy=%b, required 1 0", bus.overrun, bus.busy);
        else n_pass++;
        n_checks++;
        if (we_cnt != base_we || done_cnt != base_done)
            $display("FAIL late_activity: got writes=%0d done=%0d, required 0 0",
                     we_cnt - base_we, done_cnt - base_done);
        else n_pass++;
    endtask

    task automatic test_truncated();
        int base_we, base_done, t;
        base_we   = we_cnt;
        base_done = done_cnt;
        arm();
        push_exp(51);
        bus.VB = 1'b1;
        cen_tick();
        repeat (2) cen_tick();
        bus.busak_n = 1'b0;
        t = 0;
        while (!(bus.src_rd === 1'b1 && bus.src_addr === 10'(C_SRC + 10'd50)) && t < 500) begin
            cen_tick();
            t++;
        end
        n_checks++;
        if (t >= 500) $display("FAIL trunc_read50_timeout: got %0d pxl_cen, required < 500", t);
        else n_pass++;
        bus.VB = 1'b0;
        t = 0;
        while (bus.busrq_n !== 1'b1 && t < 10) begin
            cen_tick();
            t++;
        end
        bus.busak_n = 1'b1;
        repeat (4) cen_tick();
        n_checks++;
        if (we_cnt - base_we != 51 || exp_q.size() != 0)
            $display("FAIL trunc_writes: got %0d writes %0d pending, required 51 0",
                     we_cnt - base_we, exp_q.size());
        else n_pass++;
        n_checks++;
        if (bus.overrun !== 1'b1 || bus.busrq_n !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL trunc_status: got overrun=%b busrq_n=%b busy=%b, required 1 1 0",
                     bus.overrun, bus.busrq_n, bus.busy);
        else n_pass++;
        n_checks++;
        if (done_cnt != base_done)
            $display("FAIL trunc_done: got %0d pulses, required 0", done_cnt - base_done);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int base_we, t;
        base_we = we_cnt;
        arm();
        push_exp(20);
        bus.VB = 1'b1;
        cen_tick();
        cen_tick();
        bus.busak_n = 1'b0;
        t = 0;
        while (we_cnt - base_we < 20 && t < 500) begin
            cen_tick();
            t++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busrq_n !== 1'b1 || bus.busy !== 1'b0 || bus.src_rd !== 1'b0)
            $display("FAIL rstmid_immediate: got busrq_n=%b busy=%b src_rd=%b, required 1 0 0",
                     bus.busrq_n, bus.busy, bus.src_rd);
        else n_pass++;
        bus.busak_n = 1'b1;
        bus.VB      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cen_tick();
        n_checks++;
        if (we_cnt - base_we != 20 || exp_q.size() != 0)
            $display("FAIL rstmid_writes: got %0d writes %0d pending, required 20 0",
                     we_cnt - base_we, exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

`ifdef JTPOPEYE_DMA_WATCHDOG_EN
    task automatic test_watchdog();
        int base_done, n;
        base_done = done_cnt;
        arm();
        bus.VB = 1'b1;
        cen_tick();
        n = 0;
        while (bus.busrq_n === 1'b0 && n < 400) begin
            cen_tick();
            n++;
        end
        n_checks++;
        if (n != 255) $display("FAIL wd_exit: got %0d pxl_cen, required 255", n);
        else n_pass++;
        repeat (3) cen_tick();
        n_checks++;
        if (bus.overrun !== 1'b1 || bus.busy !== 1'b0 || done_cnt != base_done)
            $display("FAIL wd_status: got overrun=%b busy=%b done=%0d, required 1 0 0",
                     bus.overrun, bus.busy, done_cnt - base_done);
        else n_pass++;
        bus.VB = 1'b0;
        repeat (4) cen_tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        we_cnt      = 0;
        done_cnt    = 0;
        rst         = 1'b1;
        bus.VB      = 1'b0;
        bus.DM10    = 1'b0;
        bus.busak_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cen_tick();
        test_normal_copy("copy1");
        test_not_armed();
        test_grant_late();
        test_truncated();
        test_reset_mid();
        test_normal_copy("copy_after_rst");
`ifdef JTPOPEYE_DMA_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
